// File: rtl/crc_slice4_engine.sv
// crc_slice4_engine
// Slicing-by-4 reflected CRC-32 engine. Each cycle one 32-bit word sitting in
// stage 1 is folded into the running CRC through four external async-read
// lookup tables. The final CRC of each frame goes out on a valid/ready port.
// Byte 0 of a word (data[7:0]) is the first byte on the wire.
module crc_slice4_engine #(
    parameter logic [31:0] CRC_INIT = 32'hFFFF_FFFF,
    parameter logic [31:0] XOR_OUT  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic        crc_clr,
    output logic [31:0] tbl_addr0,
    output logic [31:0] tbl_addr1,
    output logic [31:0] tbl_addr2,
    output logic [31:0] tbl_addr3,
    input  logic [31:0] tbl_rdata0,
    input  logic [31:0] tbl_rdata1,
    input  logic [31:0] tbl_rdata2,
    input  logic [31:0] tbl_rdata3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_crc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FLUSH,
        S_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;

    logic        r_s1Valid;
    logic [31:0] r_s1Data;
    logic        r_s1Last;
    logic [31:0] r_crcReg;
    logic        r_outValid;
    logic [31:0] r_outCrc;

    logic        w_inReady;
    logic        w_accept;
    logic [31:0] w_x;
    logic [31:0] w_nxt;
    logic        w_frameDone;
    logic        w_outHeld;

    // Input handshake: hold off while the last word is in flight, while a result is unconsumed, or during a clear.
    always_comb begin
        w_outHeld   = r_outValid & ~out_ready;
        w_inReady   = ~crc_clr & ~(r_s1Valid & r_s1Last) & ~w_outHeld;
        w_accept    = in_valid & w_inReady;
        w_frameDone = r_s1Valid & r_s1Last & ~crc_clr;
    end

    // Table addressing and XOR fold; addresses sit at zero while stage 1 is empty.
    always_comb begin
        w_x   = r_s1Valid ? (r_crcReg ^ r_s1Data) : 32'h0;
        w_nxt = tbl_rdata0 ^ tbl_rdata1 ^ tbl_rdata2 ^ tbl_rdata3;
    end

    // Stage 1 holds the accepted word for the cycle in which it is folded in.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_s1Valid <= 1'b0;
            r_s1Data  <= 32'h0;
            r_s1Last  <= 1'b0;
        end else if (crc_clr) begin
            r_s1Valid <= 1'b0;
        end else begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1Data <= in_data;
                r_s1Last <= in_last;
            end
        end
    end

    // Running CRC: advances by one word per stage-1 word, re-seeds at frame end or clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_crcReg <= CRC_INIT;
        end else if (crc_clr) begin
            r_crcReg <= CRC_INIT;
        end else if (r_s1Valid) begin
            r_crcReg <= r_s1Last ? CRC_INIT : w_nxt;
        end
    end

    // Result register: loaded when a frame completes, held until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_outValid <= 1'b0;
            r_outCrc   <= 32'h0;
        end else if (w_frameDone) begin
            r_outValid <= 1'b1;
            r_outCrc   <= w_nxt ^ XOR_OUT;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Frame state transitions; a clear parks in HOLD only if an unconsumed result remains.
    always_comb begin
        w_stateNext = r_state;
        if (crc_clr) begin
            w_stateNext = w_outHeld ? S_HOLD : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_stateNext = in_last ? S_FLUSH : S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_accept && in_last) begin
                        w_stateNext = S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    w_stateNext = S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        if (w_accept) begin
                            w_stateNext = in_last ? S_FLUSH : S_BUSY;
                        end else begin
                            w_stateNext = S_IDLE;
                        end
                    end
                end
                default: begin
                    w_stateNext = S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_inReady;
    assign out_valid = r_outValid;
    assign out_crc   = r_outCrc;
    assign tbl_addr0 = {24'h0, w_x[7:0]};
    assign tbl_addr1 = {24'h0, w_x[15:8]};
    assign tbl_addr2 = {24'h0, w_x[23:16]};
    assign tbl_addr3 = {24'h0, w_x[31:24]};

endmodule

// File: tb/tb_crc_slice4_engine.sv
// tb_crc_slice4_engine
// Directed bench for the slicing-by-4 CRC-32 engine. The four lookup tables
// are built here from the reflected polynomial and read combinationally;
// expected CRCs are hand-computed constants.
module tb_crc_slice4_engine;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        crc_clr;
    logic [31:0] tbl_addr0;
    logic [31:0] tbl_addr1;
    logic [31:0] tbl_addr2;
    logic [31:0] tbl_addr3;
    logic [31:0] tbl_rdata0;
    logic [31:0] tbl_rdata1;
    logic [31:0] tbl_rdata2;
    logic [31:0] tbl_rdata3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_crc;

    logic [31:0] adv [4][256];
    logic [31:0] resultQ [$];
    int          checkCount = 0;
    int          errorCount = 0;

    localparam logic [31:0] WORD_1234 = 32'h3433_3231;
    localparam logic [31:0] CRC_1234  = 32'h9BE3_E0A3;
    localparam logic [31:0] WORD_ZERO = 32'h0000_0000;
    localparam logic [31:0] CRC_ZERO  = 32'h2144_DF1C;

    crc_slice4_engine dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .crc_clr    (crc_clr),
        .tbl_addr0  (tbl_addr0),
        .tbl_addr1  (tbl_addr1),
        .tbl_addr2  (tbl_addr2),
        .tbl_addr3  (tbl_addr3),
        .tbl_rdata0 (tbl_rdata0),
        .tbl_rdata1 (tbl_rdata1),
        .tbl_rdata2 (tbl_rdata2),
        .tbl_rdata3 (tbl_rdata3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_crc    (out_crc)
    );

    // adv[k] advances the CRC by k further bytes; addr0 carries byte 0 and needs 3.
    assign tbl_rdata0 = adv[3][tbl_addr0[7:0]];
    assign tbl_rdata1 = adv[2][tbl_addr1[7:0]];
    assign tbl_rdata2 = adv[1][tbl_addr2[7:0]];
    assign tbl_rdata3 = adv[0][tbl_addr3[7:0]];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every result the consumer takes, in order.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            resultQ.push_back(out_crc);
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, observed, expected);
        end
    endtask

    task automatic buildTables();
        logic [31:0] c;
        for (int b = 0; b < 256; b++) begin
            c = 32'(b);
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
            adv[0][b] = c;
        end
        for (int t = 1; t < 4; t++) begin
            for (int b = 0; b < 256; b++) begin
                adv[t][b] = (adv[t-1][b] >> 8) ^ adv[0][adv[t-1][b][7:0]];
            end
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic applyStimulus(input logic [31:0] data, input logic last);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        #0;
        for (int i = 0; i < 100 && !in_ready; i++) begin
            nextCycle();
        end
        checkOutput("acceptReady", {31'h0, in_ready}, 32'h1);
        nextCycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expectResult(input string tag, input logic [31:0] expected);
        for (int i = 0; i < 20 && resultQ.size() == 0; i++) begin
            nextCycle();
        end
        checkOutput({tag, "Count"}, 32'(resultQ.size()), 32'h1);
        if (resultQ.size() > 0) begin
            checkOutput(tag, resultQ.pop_front(), expected);
        end
    endtask

    initial begin
        buildTables();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        crc_clr   = 1'b0;
        out_ready = 1'b0;
        repeat (2) nextCycle();

        // Reset state
        checkOutput("rstOutValid", {31'h0, out_valid}, 32'h0);
        checkOutput("rstOutCrc", out_crc, 32'h0);
        checkOutput("rstInReady", {31'h0, in_ready}, 32'h1);
        checkOutput("rstAddr0", tbl_addr0, 32'h0);
        checkOutput("rstAddr1", tbl_addr1, 32'h0);
        checkOutput("rstAddr2", tbl_addr2, 32'h0);
        checkOutput("rstAddr3", tbl_addr3, 32'h0);
        rstn = 1'b1;

        // Test 1: single word "1234", one-cycle latency
        resultQ.delete();
        applyStimulus(WORD_1234, 1'b1);
        checkOutput("t1NotYet", {31'h0, out_valid}, 32'h0);
        checkOutput("t1Bubble", {31'h0, in_ready}, 32'h0);
        checkOutput("t1Addr0", tbl_addr0, 32'h0000_00CE);
        checkOutput("t1Addr3", tbl_addr3, 32'h0000_00CB);
        nextCycle();
        checkOutput("t1Valid", {31'h0, out_valid}, 32'h1);
        checkOutput("t1Crc", out_crc, CRC_1234);
        out_ready = 1'b1;
        nextCycle();
        checkOutput("t1Drop", {31'h0, out_valid}, 32'h0);

        // Test 2: zero word
        resultQ.delete();
        applyStimulus(WORD_ZERO, 1'b1);
        expectResult("t2Crc", CRC_ZERO);

        // Test 3: back-to-back frames, one bubble
        resultQ.delete();
        applyStimulus(WORD_1234, 1'b1);
        checkOutput("t3Bubble", {31'h0, in_ready}, 32'h0);
        nextCycle();
        checkOutput("t3BubbleEnd", {31'h0, in_ready}, 32'h1);
        applyStimulus(WORD_ZERO, 1'b1);
        repeat (3) nextCycle();
        checkOutput("t3Count", 32'(resultQ.size()), 32'h2);
        if (resultQ.size() == 2) begin
            checkOutput("t3First", resultQ[0], CRC_1234);
            checkOutput("t3Second", resultQ[1], CRC_ZERO);
        end

        // Test 4: consumer stalls for 5 cycles
        resultQ.delete();
        out_ready = 1'b0;
        applyStimulus(WORD_1234, 1'b1);
        nextCycle();
        in_valid = 1'b1;
        in_data  = WORD_ZERO;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t4HeldValid", {31'h0, out_valid}, 32'h1);
            checkOutput("t4HeldCrc", out_crc, CRC_1234);
            checkOutput("t4Stall", {31'h0, in_ready}, 32'h0);
            nextCycle();
        end
        out_ready = 1'b1;
        applyStimulus(WORD_ZERO, 1'b1);
        expectResult("t4First", CRC_1234);
        expectResult("t4Next", CRC_ZERO);

        // Test 5: clear mid-frame, then clear coincident with s1_last
        resultQ.delete();
        applyStimulus(32'h1122_3344, 1'b0);
        crc_clr  = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h5566_7788;
        in_last  = 1'b0;
        #1;
        checkOutput("t5ClrReady", {31'h0, in_ready}, 32'h0);
        nextCycle();
        crc_clr  = 1'b0;
        in_valid = 1'b0;
        applyStimulus(WORD_1234, 1'b1);
        crc_clr = 1'b1;
        nextCycle();
        crc_clr = 1'b0;
        checkOutput("t5ClrLast", {31'h0, out_valid}, 32'h0);
        repeat (3) nextCycle();
        checkOutput("t5NoResult", 32'(resultQ.size()), 32'h0);
        applyStimulus(WORD_1234, 1'b1);
        expectResult("t5After", CRC_1234);

        // Test 6: reset mid-frame and mid-HOLD
        resultQ.delete();
        applyStimulus(32'hDEAD_BEEF, 1'b0);
        rstn = 1'b0;
        nextCycle();
        rstn = 1'b1;
        checkOutput("t6FrameValid", {31'h0, out_valid}, 32'h0);
        checkOutput("t6FrameReady", {31'h0, in_ready}, 32'h1);
        out_ready = 1'b0;
        applyStimulus(WORD_1234, 1'b1);
        nextCycle();
        checkOutput("t6HoldValid", {31'h0, out_valid}, 32'h1);
        rstn = 1'b0;
        nextCycle();
        rstn = 1'b1;
        checkOutput("t6RstValid", {31'h0, out_valid}, 32'h0);
        checkOutput("t6RstCrc", out_crc, 32'h0);
        checkOutput("t6RstReady", {31'h0, in_ready}, 32'h1);
        out_ready = 1'b1;
        resultQ.delete();
        applyStimulus(WORD_1234, 1'b1);
        expectResult("t6After", CRC_1234);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
